ram_burst_master: RTL and testbench

RAM_BURST_MASTER -- requirements
Module: ram_burst_master

---
 rtl/ram_pkg.sv | 16 +
 rtl/ram_burst_master_if.sv | 38 +++
 rtl/burst_addr_gen.sv | 36 +++
 rtl/ram_burst_master.sv | 63 ++++++
 tb/tb_ram_burst_master.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared types and default sizes for the RAM burst master.
package ram_pkg;

  localparam int AW_DEF    = 6;
  localparam int DW_DEF    = 8;
  localparam int LW_DEF    = 3;
  localparam int MAX_BURST = 1 << LW_DEF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR       = 2'd1,
    RD_ISSUE = 2'd2,
    RD_DATA  = 2'd3
  } state_t;

endpackage

// File: rtl/ram_burst_master_if.sv
// Request, write-beat, read-beat and RAM-port signals of the burst master.
interface ram_burst_master_if
  import ram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_wnr;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_wnr;
  logic [DW-1:0] ram_q;

  // master: the burst engine itself; slave: requester plus RAM around it
  modport master (
    input  req_valid, req_wnr, req_addr, req_len, wr_data, wr_valid, rd_ready, ram_q,
    output req_ready, wr_ready, rd_data, rd_valid, busy, ram_addr, ram_data, ram_wnr
  );

  modport slave (
    output req_valid, req_wnr, req_addr, req_len, wr_data, wr_valid, rd_ready, ram_q,
    input  req_ready, wr_ready, rd_data, rd_valid, busy, ram_addr, ram_data, ram_wnr
  );

endinterface

// File: rtl/burst_addr_gen.sv
// Burst address / beat counter: loaded at request accept, stepped once per beat.
module burst_addr_gen #(
  parameter int AW = 6,
  parameter int LW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic [LW-1:0] load_len,
  input  logic          advance,
  output logic [AW-1:0] cur_addr,
  output logic [AW-1:0] next_addr,
  output logic          last
);

  logic [LW-1:0] beats_left;

  // Natural AW-bit wrap gives the modulo-2^AW address walk
  assign next_addr = cur_addr + AW'(1);
  assign last      = (beats_left == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr   <= '0;
      beats_left <= '0;
    end else if (load) begin
      cur_addr   <= load_addr;
      beats_left <= load_len;
    end else if (advance) begin
      cur_addr   <= next_addr;
      beats_left <= beats_left - LW'(1);
    end
  end

endmodule

// File: rtl/ram_burst_master.sv
// Burst master: turns single read/write burst requests into beats on a 1-cycle-latency RAM.
module ram_burst_master
  import ram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input logic               clk,
  input logic               rst_n,
  ram_burst_master_if.master bus
);

  state_t        state;
  logic          load;
  logic          advance;
  logic          last;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] next_addr;
  logic          rd_step;

  assign load    = (state == IDLE) && bus.req_valid;
  assign rd_step = (state == RD_DATA) && bus.rd_ready && !last;
  assign advance = ((state == WR) && bus.wr_valid) || rd_step;

  burst_addr_gen #(.AW(AW), .LW(LW)) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_addr (bus.req_addr),
    .load_len  (bus.req_len),
    .advance   (advance),
    .cur_addr  (cur_addr),
    .next_addr (next_addr),
    .last      (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:     if (bus.req_valid) state <= bus.req_wnr ? WR : RD_ISSUE;
        WR:       if (bus.wr_valid && last) state <= IDLE;
        RD_ISSUE: state <= RD_DATA;
        RD_DATA:  if (bus.rd_ready && last) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.wr_ready  = (state == WR);
  assign bus.rd_valid  = (state == RD_DATA);
  assign bus.rd_data   = bus.ram_q;
  assign bus.ram_data  = bus.wr_data;
  assign bus.ram_wnr   = (state == WR) && bus.wr_valid;
  // Presenting the next address while a read beat is consumed keeps 1 beat/cycle;
  // re-registering the same address on a stall keeps ram_q (and rd_data) stable.
  assign bus.ram_addr  = rd_step ? next_addr : cur_addr;

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural 64x8 RAM attached.
module tb_ram_burst_master;
  import ram_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  logic [7:0] mem [64] = '{default: 8'h00};
  logic [7:0] q;

  ram_burst_master_if #(.AW(6), .DW(8), .LW(3)) bus ();

  ram_burst_master #(.AW(6), .DW(8), .LW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_wnr) mem[bus.ram_addr] <= bus.ram_data;
    else             q <= mem[bus.ram_addr];
  end
  assign bus.ram_q = q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake lands on the next posedge; returns 1ns into cycle N+1
  task automatic start_req(input logic wnr, input logic [5:0] a, input logic [2:0] l);
    bus.req_valid = 1'b1;
    bus.req_wnr   = wnr;
    bus.req_addr  = a;
    bus.req_len   = l;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wr_ready got %b want 0", bus.wr_ready); end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid got %b want 0", bus.rd_valid); end
    n_cmp++; if (bus.ram_wnr !== 1'b0) begin n_fail++; $display("FAIL rst_ram_wnr got %b want 0", bus.ram_wnr); end
    n_cmp++; if (bus.ram_addr !== 6'd0) begin n_fail++; $display("FAIL rst_ram_addr got %0d want 0", bus.ram_addr); end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_ready got %b want 1", bus.req_ready); end
  endtask

  task automatic test_write_burst();
    start_req(1'b1, 6'd5, 3'd3);
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'(8'hA0 + i);
      #1;
      n_cmp++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready beat%0d got %b want 1", i, bus.wr_ready); end
      n_cmp++; if (bus.ram_wnr !== 1'b1) begin n_fail++; $display("FAIL wr_ram_wnr beat%0d got %b want 1", i, bus.ram_wnr); end
      n_cmp++; if (bus.ram_addr !== 6'(5 + i)) begin n_fail++; $display("FAIL wr_ram_addr beat%0d got %0d want %0d", i, bus.ram_addr, 5 + i); end
      tick();
    end
    bus.wr_valid = 1'b0;
    #1;
    n_cmp++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL wr_end_wr_ready got %b want 0", bus.wr_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL wr_end_busy got %b want 0", bus.busy); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem[5 + i] !== 8'(8'hA0 + i)) begin n_fail++; $display("FAIL wr_mem[%0d] got %h want %h", 5 + i, mem[5 + i], 8'(8'hA0 + i)); end
    end
  endtask

  task automatic test_read_burst();
    start_req(1'b0, 6'd5, 3'd3);
    bus.rd_ready = 1'b1;
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_latency_n1 got %b want 0", bus.rd_valid); end
    n_cmp++; if (bus.ram_wnr !== 1'b0) begin n_fail++; $display("FAIL rd_issue_wnr got %b want 0", bus.ram_wnr); end
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid beat%0d got %b want 1", i, bus.rd_valid); end
      n_cmp++; if (bus.rd_data !== 8'(8'hA0 + i)) begin n_fail++; $display("FAIL rd_data beat%0d got %h want %h", i, bus.rd_data, 8'(8'hA0 + i)); end
      tick();
    end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_end_valid got %b want 0", bus.rd_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rd_end_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_wrap();
    logic [7:0] wd [4];
    logic [5:0] wa [4];
    wd = '{8'h11, 8'h22, 8'h33, 8'h44};
    wa = '{6'd62, 6'd63, 6'd0, 6'd1};
    start_req(1'b1, 6'd62, 3'd3);
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.wr_data = wd[i];
      tick();
    end
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem[wa[i]] !== wd[i]) begin n_fail++; $display("FAIL wrap_mem[%0d] got %h want %h", wa[i], mem[wa[i]], wd[i]); end
    end
    start_req(1'b0, 6'd62, 3'd3);
    bus.rd_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== wd[i]) begin n_fail++; $display("FAIL wrap_rd beat%0d got v=%b d=%h want v=1 d=%h", i, bus.rd_valid, bus.rd_data, wd[i]); end
      tick();
    end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL wrap_end_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_read_stall();
    start_req(1'b0, 6'd5, 3'd3);
    bus.rd_ready = 1'b1;
    tick();
    n_cmp++; if (bus.rd_data !== 8'hA0) begin n_fail++; $display("FAIL stall_beat0 got %h want a0", bus.rd_data); end
    tick();
    bus.rd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hA1) begin n_fail++; $display("FAIL stall_hold c%0d got v=%b d=%h want v=1 d=a1", k, bus.rd_valid, bus.rd_data); end
      n_cmp++; if (bus.ram_wnr !== 1'b0 || bus.ram_addr !== 6'd6) begin n_fail++; $display("FAIL stall_ram c%0d got wnr=%b addr=%0d want wnr=0 addr=6", k, bus.ram_wnr, bus.ram_addr); end
      tick();
    end
    bus.rd_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'(8'hA0 + i)) begin n_fail++; $display("FAIL stall_resume beat%0d got v=%b d=%h want v=1 d=%h", i, bus.rd_valid, bus.rd_data, 8'(8'hA0 + i)); end
      tick();
    end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL stall_end_valid got %b want 0", bus.rd_valid); end
  endtask

  task automatic test_reset_mid_burst();
    start_req(1'b1, 6'd20, 3'd3);
    bus.wr_valid = 1'b0;
    #1;
    n_cmp++; if (bus.ram_wnr !== 1'b0 || bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL gap_no_write got wnr=%b rdy=%b want wnr=0 rdy=1", bus.ram_wnr, bus.wr_ready); end
    tick();
    bus.wr_valid = 1'b1; bus.wr_data = 8'h51;
    tick();
    bus.wr_valid = 1'b0;
    tick();
    bus.wr_valid = 1'b1; bus.wr_data = 8'h52;
    tick();
    bus.wr_data = 8'h53;
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.ram_wnr !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wnr got %b want 0", bus.ram_wnr); end
    n_cmp++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctrl got rr=%b busy=%b wr=%b want 1 0 0", bus.req_ready, bus.busy, bus.wr_ready); end
    n_cmp++; if (bus.ram_addr !== 6'd0) begin n_fail++; $display("FAIL mid_rst_addr got %0d want 0", bus.ram_addr); end
    tick();
    rst_n = 1'b1;
    bus.wr_valid = 1'b0;
    tick();
    n_cmp++; if (bus.busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.ram_wnr !== 1'b0 || bus.ram_addr !== 6'd0) begin n_fail++; $display("FAIL post_mid_rst got busy=%b rv=%b wnr=%b addr=%0d want 0 0 0 0", bus.busy, bus.rd_valid, bus.ram_wnr, bus.ram_addr); end
    n_cmp++; if (mem[20] !== 8'h51 || mem[21] !== 8'h52) begin n_fail++; $display("FAIL mid_rst_written got %h %h want 51 52", mem[20], mem[21]); end
    n_cmp++; if (mem[22] !== 8'h00 || mem[23] !== 8'h00) begin n_fail++; $display("FAIL mid_rst_abandoned got %h %h want 00 00", mem[22], mem[23]); end
  endtask

  task automatic test_back_to_back();
    bus.req_valid = 1'b1; bus.req_wnr = 1'b1; bus.req_addr = 6'd40; bus.req_len = 3'd0;
    tick();
    bus.req_wnr = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_data = 8'h77;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b0 || bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_ignore got rr=%b wr=%b want 0 1", bus.req_ready, bus.wr_ready); end
    tick();
    bus.wr_valid = 1'b0;
    n_cmp++; if (bus.req_ready !== 1'b1 || bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap got rr=%b wr=%b want 1 0", bus.req_ready, bus.wr_ready); end
    tick();
    bus.req_valid = 1'b0;
    bus.rd_ready  = 1'b1;
    n_cmp++; if (bus.busy !== 1'b1 || bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_rd_issue got busy=%b rv=%b want 1 0", bus.busy, bus.rd_valid); end
    tick();
    n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h77) begin n_fail++; $display("FAIL b2b_rd_data got v=%b d=%h want v=1 d=77", bus.rd_valid, bus.rd_data); end
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy got %b want 0", bus.busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_wnr   = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b0;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_read_stall();
    test_reset_mid_burst();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
